ram_port_arbiter: RTL and testbench

Two-client arbiter that shares the single command path of the 512×8 `memory` block between two requesters. Each cycle it grants at most one read or write with round-robin fairness, and registers the command onto the memory ports. It returns a completion pulse to the owning client, with read data where applicable. Accesses beyond the physical depth are rejected with an error and never reach the array.

---
 rtl/ram_port_arbiter_pkg.sv | 28 ++
 rtl/ram_port_arbiter_if.sv | 35 +++
 rtl/ram_port_arbiter_rr_arb2.sv | 40 ++++
 rtl/ram_port_arbiter.sv | 113 +++++++++++
 tb/tb_ram_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and record types for the two-client RAM port arbiter.
// The widths and depth match the 512x8 memory block behind the arbiter.
package ram_arb_pkg;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 10;
  localparam int DEPTH       = 512;
  localparam int NUM_CLIENTS = 2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // owner is a client index; one bit covers both clients
  typedef struct packed {
    logic valid;
    logic owner;
    logic we;
    logic err;
  } stage_t;

  function automatic logic addr_illegal(input logic [ADDR_W-1:0] addr, input int depth);
    return int'(addr) >= depth;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Client handshakes and memory-side command path of the RAM port arbiter.
// master = clients plus memory, slave = the arbiter.
interface ram_port_arbiter_if #(
  parameter int DATA_W = ram_arb_pkg::DATA_W,
  parameter int ADDR_W = ram_arb_pkg::ADDR_W
);

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;

  logic              mem_write;
  logic [ADDR_W-1:0] mem_write_address;
  logic [ADDR_W-1:0] mem_read_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
    input  mem_write, mem_write_address, mem_read_address, mem_data_in
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
    output mem_write, mem_write_address, mem_read_address, mem_data_in
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-input round-robin grant. The prio pointer names the client that wins
// a tie, and it moves to the other client after every grant.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] req,
  output logic [NUM_CLIENTS-1:0] gnt
);

  logic prio_q, prio_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt    = '0;
    prio_d = prio_q;
    if (!rst) begin
      if (req[0] && (!req[1] || !prio_q)) begin
        gnt[0] = 1'b1;
      end else if (req[1]) begin
        gnt[1] = 1'b1;
      end
    end
    if (|gnt) begin
      prio_d = gnt[0];
    end
  end

  // NOTE: reset is synchronous and active-high; it is sampled only on the rising clock edge.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single command path of a 512x8 memory between two clients:
// round-robin grant, S1 issue register onto mem_*, S2 response with done/err/rdata.
module ram_port_arbiter
  import ram_arb_pkg::cmd_t, ram_arb_pkg::stage_t, ram_arb_pkg::addr_illegal;
#(
  parameter int DATA_W = ram_arb_pkg::DATA_W,
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DEPTH  = ram_arb_pkg::DEPTH
) (
  input logic                clk,
  input logic                rst,
  ram_port_arbiter_if.slave  bus
);

  logic [1:0] req_v, gnt_v;
  cmd_t       cmd0, cmd1, sel;
  logic       sel_illegal;

  stage_t s1_q, s1_d;
  stage_t s2_q, s2_d;

  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              done0, done1, rd_ok;

  assign req_v = {bus.req1, bus.req0};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_v),
    .gnt (gnt_v)
  );

  assign bus.gnt0 = gnt_v[0];
  assign bus.gnt1 = gnt_v[1];

  always_comb begin
    cmd0        = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
    cmd1        = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
    sel         = gnt_v[1] ? cmd1 : cmd0;
    sel_illegal = addr_illegal(sel.addr, DEPTH);
  end

  // Issue stage: rejected or absent commands leave the address/data ports
  // untouched and only drop mem_write, so the array cannot be modified.
  always_comb begin
    s1_d        = '{valid: |gnt_v, owner: gnt_v[1], we: sel.we, err: sel_illegal};
    mem_write_d = 1'b0;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    din_d       = din_q;
    if (|gnt_v && !sel_illegal) begin
      if (sel.we) begin
        mem_write_d = 1'b1;
        waddr_d     = sel.addr;
        din_d       = sel.wdata;
      end else begin
        raddr_d     = sel.addr;
      end
    end
  end

  // Response stage: the memory's read data arrives during the S2 cycle, so it
  // is steered straight to the owner and captured for the hold value.
  always_comb begin
    s2_d     = s1_q;
    done0    = s2_q.valid && !s2_q.owner;
    done1    = s2_q.valid &&  s2_q.owner;
    rd_ok    = !s2_q.we && !s2_q.err;
    rdata0_d = (done0 && rd_ok) ? bus.mem_data_out : rdata0_q;
    rdata1_d = (done1 && rd_ok) ? bus.mem_data_out : rdata1_q;
  end

  assign bus.done0  = done0;
  assign bus.done1  = done1;
  assign bus.err0   = done0 && s2_q.err;
  assign bus.err1   = done1 && s2_q.err;
  assign bus.rdata0 = rdata0_d;
  assign bus.rdata1 = rdata1_d;

  assign bus.mem_write         = mem_write_q;
  assign bus.mem_write_address = waddr_q;
  assign bus.mem_read_address  = raddr_q;
  assign bus.mem_data_in       = din_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      mem_write_q <= 1'b0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      din_q       <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      mem_write_q <= mem_write_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      din_q       <= din_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: memory model, cycle-scheduled
// response model, per-cycle compare and directed scenarios.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int MW = $clog2(DEPTH);

  typedef struct packed {
    logic              owner;
    logic              we;
    logic              err;
    logic [DATA_W-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_port_arbiter_if bus ();

  ram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return DATA_W'(i) ^ 8'h5A;
  endfunction

  // 512x8 synchronous memory: write and registered read on the rising edge
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] mem_dout;
  initial foreach (ram[i]) ram[i] = init_val(i);
  always @(posedge clk) begin
    if (bus.mem_write === 1'b1) ram[bus.mem_write_address[MW-1:0]] <= bus.mem_data_in;
    mem_dout <= ram[bus.mem_read_address[MW-1:0]];
  end
  assign bus.mem_data_out = mem_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: shadow memory updated at grant time, responses scheduled by cycle.
  logic [DATA_W-1:0] shadow [DEPTH];
  initial foreach (shadow[i]) shadow[i] = init_val(i);
  resp_t             sched [int];
  bit                cmp_en = 1'b0;
  bit                m_prio = 1'b0;
  logic              m_memw = 1'b0;
  logic [ADDR_W-1:0] m_waddr = '0, m_raddr = '0;
  logic [DATA_W-1:0] m_din = '0, h0 = '0, h1 = '0;
  int                act_cnt = 0;
  int                gnt_log[$], gnt_cyc[$], done_log[$], done_cyc[$];

  always @(negedge clk) begin : model
    bit                eg0, eg1, has, ed0, ed1, c_bad;
    resp_t             r;
    logic [DATA_W-1:0] er0, er1, c_data;
    logic [ADDR_W-1:0] c_addr;
    logic              c_we;

    if (rst) begin
      eg0 = 1'b0; eg1 = 1'b0;
    end else if (bus.req0 && bus.req1) begin
      eg0 = !m_prio; eg1 = m_prio;
    end else begin
      eg0 = bus.req0; eg1 = bus.req1;
    end
    has = sched.exists(cyc);
    r   = has ? sched[cyc] : '0;
    ed0 = has && !r.owner;
    ed1 = has &&  r.owner;
    er0 = (ed0 && !r.we && !r.err) ? r.data : h0;
    er1 = (ed1 && !r.we && !r.err) ? r.data : h1;

    if (cmp_en) begin
      check("gnt0", bus.gnt0, eg0);
      check("gnt1", bus.gnt1, eg1);
      check("done0", bus.done0, ed0);
      check("done1", bus.done1, ed1);
      check("err0", bus.err0, ed0 && r.err);
      check("err1", bus.err1, ed1 && r.err);
      check("rdata0", bus.rdata0, er0);
      check("rdata1", bus.rdata1, er1);
      check("mem_write", bus.mem_write, m_memw);
      check("mem_write_address", bus.mem_write_address, m_waddr);
      check("mem_read_address", bus.mem_read_address, m_raddr);
      check("mem_data_in", bus.mem_data_in, m_din);
    end
    h0 = er0;
    h1 = er1;

    if (bus.gnt0 === 1'b1) begin gnt_log.push_back(0); gnt_cyc.push_back(cyc); end
    if (bus.gnt1 === 1'b1) begin gnt_log.push_back(1); gnt_cyc.push_back(cyc); end
    if (bus.done0 === 1'b1) begin done_log.push_back(0); done_cyc.push_back(cyc); end
    if (bus.done1 === 1'b1) begin done_log.push_back(1); done_cyc.push_back(cyc); end
    if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1 || bus.done0 === 1'b1 ||
        bus.done1 === 1'b1 || bus.mem_write === 1'b1) act_cnt++;

    m_memw = 1'b0;
    if (rst) begin
      m_prio  = 1'b0;
      m_waddr = '0;
      m_raddr = '0;
      m_din   = '0;
      h0      = '0;
      h1      = '0;
      sched.delete(cyc + 1);
      sched.delete(cyc + 2);
      cmp_en  = 1'b1;
    end else if (eg0 || eg1) begin
      c_we    = eg1 ? bus.we1 : bus.we0;
      c_addr  = eg1 ? bus.addr1 : bus.addr0;
      c_data  = eg1 ? bus.wdata1 : bus.wdata0;
      c_bad   = int'(c_addr) >= DEPTH;
      r       = '{owner: eg1, we: c_we, err: c_bad, data: '0};
      if (!c_bad && c_we) begin
        shadow[c_addr[MW-1:0]] = c_data;
        m_memw  = 1'b1;
        m_waddr = c_addr;
        m_din   = c_data;
      end else if (!c_bad) begin
        r.data  = shadow[c_addr[MW-1:0]];
        m_raddr = c_addr;
      end
      sched[cyc + 2] = r;
      m_prio = eg0;
    end
    sched.delete(cyc);
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Presents a command, holds it until granted, then drops req after the grant edge.
  task automatic cmd(input int k, input bit we, input int addr, input int wdata, output int gcyc);
    bit got = 1'b0;
    gcyc = -1;
    if (k == 0) begin
      bus.we0 = we; bus.addr0 = ADDR_W'(addr); bus.wdata0 = DATA_W'(wdata); bus.req0 = 1'b1;
    end else begin
      bus.we1 = we; bus.addr1 = ADDR_W'(addr); bus.wdata1 = DATA_W'(wdata); bus.req1 = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (((k == 0) ? bus.gnt0 : bus.gnt1) === 1'b1) begin
        got  = 1'b1;
        gcyc = cyc;
      end
    end
    if (!got) check($sformatf("gnt_timeout_%0d", k), 0, 1);
    sync();
    if (k == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
  endtask

  task automatic wait_done(input int k, output logic [DATA_W-1:0] rd, output logic er, output int dc);
    bit got = 1'b0;
    rd = '0; er = 1'b0; dc = -1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (((k == 0) ? bus.done0 : bus.done1) === 1'b1) begin
        got = 1'b1;
        rd  = (k == 0) ? bus.rdata0 : bus.rdata1;
        er  = (k == 0) ? bus.err0 : bus.err1;
        dc  = cyc;
      end
    end
    if (!got) check($sformatf("done_timeout_%0d", k), 0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int                g, g0, g1, d, a;
    logic [DATA_W-1:0] rd;
    logic              er;

    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // contention straight out of reset: grants and completions alternate 0,1,...
    fork
      begin
        int gg;
        for (int i = 0; i < 3; i++) cmd(0, 1'b1, 20 + i, 8'h20 + i, gg);
      end
      begin
        int gg;
        for (int i = 0; i < 3; i++) cmd(1, 1'b0, 40 + i, 0, gg);
      end
    join
    repeat (3) sync();
    check("cont_gnt_count", gnt_log.size(), 6);
    check("cont_done_count", done_log.size(), 6);
    if (gnt_log.size() >= 6 && done_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("cont_gnt_order_%0d", i), gnt_log[i], i % 2);
        check($sformatf("cont_done_order_%0d", i), done_log[i], i % 2);
        check($sformatf("cont_done_lat_%0d", i), done_cyc[i], gnt_cyc[i] + 2);
      end
    end

    // single write then read of addr 3
    sync();
    cmd(0, 1'b1, 3, 8'hA5, g);
    wait_done(0, rd, er, d);
    check("wr_done_lat", d, g + 2);
    check("wr_err", er, 1'b0);
    sync();
    cmd(0, 1'b0, 3, 0, g);
    wait_done(0, rd, er, d);
    check("rd_done_lat", d, g + 2);
    check("rd_data", rd, 8'hA5);
    check("rd_err", er, 1'b0);

    // out-of-range write must not touch addr 600 & 0x1FF = 88
    sync();
    cmd(1, 1'b1, 600, 8'h3C, g);
    check("oor_mem_write", bus.mem_write, 1'b0);
    wait_done(1, rd, er, d);
    check("oor_done_lat", d, g + 2);
    check("oor_err", er, 1'b1);
    sync();
    cmd(1, 1'b0, 88, 0, g);
    wait_done(1, rd, er, d);
    check("oor_alias_data", rd, 8'h02);
    check("oor_alias_err", er, 1'b0);

    // back-to-back read-after-write at the last legal address
    sync();
    fork
      cmd(0, 1'b1, 511, 8'h11, g0);
      begin
        sync();
        cmd(1, 1'b0, 511, 0, g1);
        wait_done(1, rd, er, d);
      end
    join
    check("raw_gnt_spacing", g1, g0 + 1);
    check("raw_data", rd, 8'h11);
    check("raw_err", er, 1'b0);
    check("raw_done_lat", d, g1 + 2);

    // reset while a read is in flight
    sync();
    bus.we0 = 1'b0; bus.addr0 = 10'd5; bus.req0 = 1'b1;
    @(negedge clk);
    check("rst_pre_gnt0", bus.gnt0, 1'b1);
    sync();
    bus.req0 = 1'b0;
    rst = 1'b1;
    sync();
    bus.we1 = 1'b0; bus.addr1 = 10'd7; bus.req0 = 1'b1; bus.req1 = 1'b1;
    @(negedge clk);
    check("rst_done0", bus.done0, 1'b0);
    check("rst_done1", bus.done1, 1'b0);
    check("rst_gnt0", bus.gnt0, 1'b0);
    check("rst_gnt1", bus.gnt1, 1'b0);
    check("rst_err0", bus.err0, 1'b0);
    check("rst_err1", bus.err1, 1'b0);
    check("rst_rdata0", bus.rdata0, 0);
    check("rst_rdata1", bus.rdata1, 0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_mem_waddr", bus.mem_write_address, 0);
    check("rst_mem_raddr", bus.mem_read_address, 0);
    check("rst_mem_din", bus.mem_data_in, 0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("rst_first_gnt0", bus.gnt0, 1'b1);
    check("rst_first_gnt1", bus.gnt1, 1'b0);
    sync();
    bus.req0 = 1'b0;
    sync();
    bus.req1 = 1'b0;

    // idle: nothing moves for 10 cycles
    repeat (4) sync();
    a = act_cnt;
    repeat (10) sync();
    check("idle_activity", act_cnt - a, 0);

    repeat (2) sync();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
